// File: rtl/sprite_anim_fetch.sv
// Per-pixel sprite fetch: descriptor table, frame sequencer, mirror/scale/blank, sheet memory port.
// Latency 4 cycles from px_valid to pix_valid, one pixel per cycle; no backpressure, never stalls.
module sprite_anim_fetch #(
    parameter int NUM_ANIM = 10,
    parameter int ADDR_W   = 17,
    parameter int PIX_W    = 4,
    parameter int W_W      = 7,
    parameter int FRAME_H  = 105,
    parameter int SCALE_SH = 1,
    parameter int TRANSP   = 0,
    localparam int AS      = $clog2(NUM_ANIM)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              desc_we,
    input  logic [AS-1:0]     desc_idx,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [W_W-1:0]    desc_width,
    input  logic [2:0]        desc_frames,
    input  logic [3:0]        desc_ticks,
    input  logic              desc_loop,
    input  logic [AS-1:0]     anim_sel,
    input  logic              frame_tick,
    input  logic              mirror,
    input  logic              px_valid,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_q,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_out,
    output logic [AS-1:0]     cur_anim,
    output logic [2:0]        cur_frame,
    output logic              anim_done
);

    localparam int RW = $clog2(FRAME_H);
    localparam logic [AS:0]      NUM_ANIM_L = (AS+1)'(NUM_ANIM);
    localparam logic [7:0]       FRAME_H_L  = 8'(FRAME_H);
    localparam logic [PIX_W-1:0] TRANSP_L   = PIX_W'(TRANSP);

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [W_W-1:0]    width;
        logic [2:0]        frames;
        logic [3:0]        ticks;
        logic              loop;
    } desc_t;

    desc_t desc_tbl [NUM_ANIM];
    desc_t cur_d, sel_d;
    logic  sel_ok, idx_ok;
    logic [3:0] tick_cnt;
    logic [4:0] tick_nxt;
    logic [2:0] last_frame;

    // Zero frame/tick counts are stored as 1 so the sequencer never sees them.
    assign idx_ok = ({1'b0, desc_idx} < NUM_ANIM_L);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ANIM; i++)
                desc_tbl[i] <= '{base: '0, width: W_W'(50), frames: 3'd1, ticks: 4'd1, loop: 1'b1};
        end else if (desc_we && idx_ok) begin
            desc_tbl[desc_idx] <= '{base:   desc_base,
                                    width:  desc_width,
                                    frames: (desc_frames == 3'd0) ? 3'd1 : desc_frames,
                                    ticks:  (desc_ticks == 4'd0) ? 4'd1 : desc_ticks,
                                    loop:   desc_loop};
        end
    end

    assign cur_d      = desc_tbl[cur_anim];
    assign sel_ok     = ({1'b0, anim_sel} < NUM_ANIM_L);
    assign sel_d      = sel_ok ? desc_tbl[anim_sel] : '0;
    assign tick_nxt   = {1'b0, tick_cnt} + 5'd1;
    assign last_frame = cur_d.frames - 3'd1;

    // An out-of-range selection is treated as "no change request": the current animation keeps ticking.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur_anim  <= '0;
            cur_frame <= '0;
            tick_cnt  <= '0;
            anim_done <= 1'b0;
        end else begin
            anim_done <= 1'b0;
            if (frame_tick) begin
                if (sel_ok && (anim_sel != cur_anim)) begin
                    cur_anim  <= anim_sel;
                    cur_frame <= '0;
                    tick_cnt  <= '0;
                    anim_done <= !sel_d.loop && (sel_d.frames == 3'd1);
                end else if (tick_nxt >= {1'b0, cur_d.ticks}) begin
                    tick_cnt <= '0;
                    if (cur_frame < last_frame) begin
                        cur_frame <= cur_frame + 3'd1;
                        anim_done <= !cur_d.loop && ((cur_frame + 3'd1) == last_frame);
                    end else if (cur_d.loop) begin
                        cur_frame <= '0;
                    end
                end else begin
                    tick_cnt <= tick_nxt[3:0];
                end
            end
        end
    end

    // S1: scale down, bounds test, mirror; descriptor and frame are captured with the pixel.
    logic [7:0] xs, ys, w8, col8;
    logic       px_blank;
    assign xs       = x >> SCALE_SH;
    assign ys       = y >> SCALE_SH;
    assign w8       = 8'(cur_d.width);
    assign px_blank = (xs >= w8) || (ys >= FRAME_H_L);
    assign col8     = mirror ? (w8 - 8'd1 - xs) : xs;

    logic              s1_vld, s2_vld, s3_vld;
    logic              s1_blank, s2_blank, s3_blank;
    logic [W_W-1:0]    s1_col, s1_width;
    logic [RW-1:0]     s1_row;
    logic [ADDR_W-1:0] s1_base, addr_s2;
    logic [2:0]        s1_frames, s1_frame;

    always_ff @(posedge clock) begin
        s1_col    <= px_blank ? '0 : W_W'(col8);
        s1_row    <= px_blank ? '0 : RW'(ys);
        s1_base   <= cur_d.base;
        s1_width  <= cur_d.width;
        s1_frames <= cur_d.frames;
        s1_frame  <= cur_frame;
    end

    // Frames of one animation sit side by side on the sheet, so a row spans width*frames.
    assign addr_s2 = s1_base
                   + ADDR_W'(s1_row) * ADDR_W'(s1_width) * ADDR_W'(s1_frames)
                   + ADDR_W'(s1_frame) * ADDR_W'(s1_width)
                   + ADDR_W'(s1_col);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            s1_blank  <= 1'b0;
            s2_blank  <= 1'b0;
            s3_blank  <= 1'b0;
            mem_addr  <= '0;
            pix_valid <= 1'b0;
            pix_out   <= TRANSP_L;
        end else begin
            s1_vld    <= px_valid;
            s1_blank  <= px_blank;
            s2_vld    <= s1_vld;
            s2_blank  <= s1_blank;
            mem_addr  <= addr_s2;
            s3_vld    <= s2_vld;
            s3_blank  <= s2_blank;
            pix_valid <= s3_vld;
            if (s3_vld)
                pix_out <= s3_blank ? TRANSP_L : mem_q;
        end
    end

endmodule

// File: tb/tb_sprite_anim_fetch.sv
// Bench for sprite_anim_fetch: directed scenarios plus random traffic against a table-level model,
// with a scoreboard queue drained by an independent output monitor.
module tb_sprite_anim_fetch;

    localparam int NA = 10;
    localparam int FH = 105;

    logic        clock = 1'b0, resetn = 1'b0, desc_we = 1'b0;
    logic [3:0]  desc_idx = '0;
    logic [16:0] desc_base = '0;
    logic [6:0]  desc_width = '0;
    logic [2:0]  desc_frames = '0;
    logic [3:0]  desc_ticks = '0;
    logic        desc_loop = 1'b0;
    logic [3:0]  anim_sel = '0;
    logic        frame_tick = 1'b0, mirror = 1'b0, px_valid = 1'b0;
    logic [7:0]  x = '0, y = '0;
    logic [16:0] mem_addr;
    logic [3:0]  mem_q = '0;
    logic        pix_valid;
    logic [3:0]  pix_out;
    logic [3:0]  cur_anim;
    logic [2:0]  cur_frame;
    logic        anim_done;

    sprite_anim_fetch dut (
        .clock(clock), .resetn(resetn), .desc_we(desc_we), .desc_idx(desc_idx),
        .desc_base(desc_base), .desc_width(desc_width), .desc_frames(desc_frames),
        .desc_ticks(desc_ticks), .desc_loop(desc_loop), .anim_sel(anim_sel),
        .frame_tick(frame_tick), .mirror(mirror), .px_valid(px_valid), .x(x), .y(y),
        .mem_addr(mem_addr), .mem_q(mem_q), .pix_valid(pix_valid), .pix_out(pix_out),
        .cur_anim(cur_anim), .cur_frame(cur_frame), .anim_done(anim_done)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] rom_f(input logic [16:0] a);
        logic [31:0] h;
        h = {15'd0, a} * 32'h9E3779B1;
        return h[31:28];
    endfunction

    always @(posedge clock) mem_q <= rom_f(mem_addr);

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: descriptor table, displayed animation/frame, ticks spent in current frame.
    int m_base[NA], m_width[NA], m_frames[NA], m_ticks[NA], m_loop[NA];
    int m_anim, m_frame, m_tick, m_done;

    typedef struct { int pix; int cyc; } exp_t;
    exp_t sbq[$];
    int   last_pix = 0;
    bit   mon_en = 0;

    task automatic m_reset();
        for (int i = 0; i < NA; i++) begin
            m_base[i] = 0; m_width[i] = 50; m_frames[i] = 1; m_ticks[i] = 1; m_loop[i] = 1;
        end
        m_anim = 0; m_frame = 0; m_tick = 0; m_done = 0;
        sbq.delete();
        last_pix = 0;
    endtask

    task automatic model_pix(input int xv, input int yv, input int mir, output int addr, output int pix);
        int xs, ys, w, col, row;
        bit blank;
        xs = xv >> 1; ys = yv >> 1; w = m_width[m_anim];
        blank = (xs >= w) || (ys >= FH);
        col = blank ? 0 : (mir != 0 ? w - 1 - xs : xs);
        row = blank ? 0 : ys;
        addr = (m_base[m_anim] + row * w * m_frames[m_anim] + m_frame * w + col) % 131072;
        pix = blank ? 0 : int'(rom_f(17'(addr)));
    endtask

    // One clock: predict from pre-edge state, advance model, then compare sequencer outputs.
    task automatic cycle();
        int n_anim, n_frame, n_tick, n_done, a, p, s;
        exp_t e;
        n_anim = m_anim; n_frame = m_frame; n_tick = m_tick; n_done = 0;
        if (resetn) begin
            if (px_valid) begin
                model_pix(int'(x), int'(y), int'(mirror), a, p);
                e.pix = p; e.cyc = cyc;
                sbq.push_back(e);
            end
            if (frame_tick) begin
                s = int'(anim_sel);
                if (s != m_anim && s < NA) begin
                    n_anim = s; n_frame = 0; n_tick = 0;
                    n_done = (m_loop[s] == 0 && m_frames[s] == 1) ? 1 : 0;
                end else begin
                    n_tick = m_tick + 1;
                    if (n_tick >= m_ticks[m_anim]) begin
                        n_tick = 0;
                        if (m_frame < m_frames[m_anim] - 1) begin
                            n_frame = m_frame + 1;
                            n_done = (m_loop[m_anim] == 0 && n_frame == m_frames[m_anim] - 1) ? 1 : 0;
                        end else if (m_loop[m_anim] != 0) begin
                            n_frame = 0;
                        end
                    end
                end
            end
            if (desc_we && int'(desc_idx) < NA) begin
                m_base[desc_idx]   = int'(desc_base);
                m_width[desc_idx]  = int'(desc_width);
                m_frames[desc_idx] = (desc_frames == 0) ? 1 : int'(desc_frames);
                m_ticks[desc_idx]  = (desc_ticks == 0) ? 1 : int'(desc_ticks);
                m_loop[desc_idx]   = int'(desc_loop);
            end
        end
        @(posedge clock);
        #1;
        m_anim = n_anim; m_frame = n_frame; m_tick = n_tick; m_done = n_done;
        chk("cur_anim", int'(cur_anim), m_anim);
        chk("cur_frame", int'(cur_frame), m_frame);
        chk("anim_done", int'(anim_done), m_done);
    endtask

    task automatic write_desc(input int idx, input int base, input int w, input int f, input int t, input int l);
        desc_we = 1'b1; desc_idx = 4'(idx); desc_base = 17'(base); desc_width = 7'(w);
        desc_frames = 3'(f); desc_ticks = 4'(t); desc_loop = 1'(l);
        cycle();
        desc_we = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic pixel(input int xv, input int yv, input int mir);
        px_valid = 1'b1; x = 8'(xv); y = 8'(yv); mirror = 1'(mir);
        cycle();
        px_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (pix_valid) begin
                if (sbq.size() == 0) begin
                    chk("pix_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("pix_latency", cyc, e.cyc + 4);
                    chk("pix_out", int'(pix_out), e.pix);
                    last_pix = e.pix;
                end
            end else begin
                chk("pix_hold", int'(pix_out), last_pix);
            end
        end
    end

    int exp3a[5] = '{1, 2, 3, 0, 1};
    int exp3b[6] = '{1, 1, 2, 2, 2, 3};
    int exp4[4]  = '{0, 1, 2, 2};

    initial begin
        int done_cnt, done_at, lim, w;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_cur_anim", int'(cur_anim), 0);
        chk("rst_cur_frame", int'(cur_frame), 0);
        chk("rst_anim_done", int'(anim_done), 0);
        resetn = 1'b1;
        mon_en = 1;

        // Basic fetch, mirrored fetch, out-of-bounds column.
        write_desc(0, 0, 50, 4, 1, 1);
        pixel(3, 5, 0);
        cycle();
        chk("t1_addr", int'(mem_addr), 401);
        pixel(3, 5, 1);
        cycle();
        chk("t2_mirror_addr", int'(mem_addr), 448);
        pixel(100, 5, 0);
        repeat (3) cycle();
        chk("t2_blank_valid", int'(pix_valid), 1);
        chk("t2_blank_pix", int'(pix_out), 0);

        // Frame sequencing, then slowed to one advance per three ticks.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_frame", int'(cur_frame), exp3a[i]);
        end
        write_desc(0, 0, 50, 4, 3, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_slow_frame", int'(cur_frame), exp3b[i]);
        end

        // One-shot animation.
        write_desc(4, 20000, 64, 3, 1, 0);
        anim_sel = 4'd4;
        done_cnt = 0; done_at = -1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (anim_done) begin done_cnt++; done_at = i; end
            chk("t4_frame", int'(cur_frame), exp4[i]);
        end
        chk("t4_done_count", done_cnt, 1);
        chk("t4_done_tick", done_at, 2);
        pixel(0, 0, 0);
        cycle();
        chk("t4_addr", int'(mem_addr), 20128);

        // Selection only on ticks; out-of-range selection ignored.
        anim_sel = 4'd2;
        repeat (3) cycle();
        chk("t5_no_tick_anim", int'(cur_anim), 4);
        tick();
        chk("t5_tick_anim", int'(cur_anim), 2);
        chk("t5_tick_frame", int'(cur_frame), 0);
        anim_sel = 4'd12;
        tick();
        chk("t5_bad_sel", int'(cur_anim), 2);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            desc_we = ($urandom_range(0, 9) == 0);
            if (desc_we) begin
                desc_idx = 4'($urandom_range(0, 15));
                desc_base = 17'($urandom);
                desc_width = 7'($urandom_range(1, 127));
                desc_frames = 3'($urandom_range(0, 7));
                desc_ticks = 4'($urandom_range(0, 3));
                desc_loop = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 19) == 0) anim_sel = 4'($urandom_range(0, 15));
            frame_tick = ($urandom_range(0, 4) == 0);
            px_valid = ($urandom_range(0, 9) < 7);
            mirror = 1'($urandom_range(0, 1));
            w = m_width[m_anim];
            lim = 2 * w + 3;
            if (lim > 255) lim = 255;
            x = $urandom_range(0, 1) ? 8'($urandom_range(0, lim)) : 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 215));
            cycle();
        end
        desc_we = 1'b0; frame_tick = 1'b0; px_valid = 1'b0;

        // Reset in the middle of a pixel stream.
        px_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = 8'(2 * i); y = 8'(i);
            if (i == 3) begin
                resetn = 1'b0;
                m_reset();
            end
            cycle();
            if (i >= 3) begin
                chk("t6_rst_pix_valid", int'(pix_valid), 0);
                chk("t6_rst_mem_addr", int'(mem_addr), 0);
                chk("t6_rst_pix_out", int'(pix_out), 0);
            end
        end
        px_valid = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t6_no_pix_after_rst", int'(pix_valid), 0);
        end

        // Drain and confirm every predicted pixel was produced.
        for (int i = 0; i < 10 && sbq.size() != 0; i++) cycle();
        chk("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
